// File: rtl/gpio_port_bridge_if.sv
// ---------------------------------------------------------------------------
// gpio_port_bridge_if
//   Data-bus connection between the core's address decoder and the GPIO port
//   bridge. The decoder side (master) drives a one-cycle request. The bridge
//   side (slave) returns registered read data.
//
//   SEL      request targets the bridge this cycle
//   ADDR     byte offset within the bridge window (bits [1:0] ignored)
//   D_RW     1 = write, 0 = read, qualified by SEL
//   DDATA_W  write data
//   DDATA_R  registered read data
// ---------------------------------------------------------------------------
interface gpio_port_bridge_if;
  logic        SEL;
  logic [3:0]  ADDR;
  logic        D_RW;
  logic [31:0] DDATA_W;
  logic [31:0] DDATA_R;

  modport master (
    output SEL,
    output ADDR,
    output D_RW,
    output DDATA_W,
    input  DDATA_R
  );

  modport slave (
    input  SEL,
    input  ADDR,
    input  D_RW,
    input  DDATA_W,
    output DDATA_R
  );
endinterface

// File: rtl/gpio_port_bridge.sv
// ---------------------------------------------------------------------------
// gpio_port_bridge
//   Memory-mapped DW-bit I/O port. Core stores drive the DOUT pin register.
//   The asynchronous DIN pins are synchronised and change-detected. Every new
//   DIN value is queued in a small capture FIFO, which the core drains by
//   loads from the POP register.
//
//   Register map (word offsets, ADDR[1:0] ignored):
//     0x0 DOUT   RW  [DW-1:0]
//     0x4 DIN    RO  current synchronised pin value
//     0x8 STATUS     [7:0] count, [8] empty, [9] full, [10] overflow (W1C)
//     0xC POP    RO  FIFO head; the read also pops the entry (0 when empty)
//
//   Ports:
//     CLK    system clock; all logic runs on the rising edge
//     RESET  synchronous, active-high reset
//     bus    slave side of the core data-bus interface
//     DIN    asynchronous input pins
//     DOUT   output pin register
//     IRQ    high while the capture FIFO holds at least one entry (registered)
// ---------------------------------------------------------------------------
module gpio_port_bridge #(
  parameter int            FIFO_DEPTH = 4,
  parameter int            DW         = 16,
  parameter logic [DW-1:0] DOUT_RST   = '0
) (
  input  logic               CLK,
  input  logic               RESET,
  gpio_port_bridge_if.slave  bus,
  input  logic [DW-1:0]      DIN,
  output logic [DW-1:0]      DOUT,
  output logic               IRQ
);

  // Pointer width. The depth is a power of two, so the pointers wrap
  // modulo FIFO_DEPTH without any compare logic.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // The count needs one extra value to represent "full".
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] IDX_DOUT   = 2'd0;
  localparam logic [1:0] IDX_DIN    = 2'd1;
  localparam logic [1:0] IDX_STATUS = 2'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DW-1:0] s1_reg;
  logic [DW-1:0] s2_reg;
  logic [DW-1:0] prev_reg;
  logic          primed_reg;

  logic [DW-1:0] dout_reg;
  logic [31:0]   ddata_r_reg;
  logic [31:0]   ddata_r_next;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          ovf_reg;
  logic          ovf_next;
  logic          irq_reg;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic       bus_rd;
  logic       bus_wr;
  logic [1:0] reg_idx;

  assign bus_rd  = bus.SEL & ~bus.D_RW;
  assign bus_wr  = bus.SEL &  bus.D_RW;
  assign reg_idx = bus.ADDR[3:2];

  // The low address bits and the upper write-data bits carry no meaning here.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.ADDR[1:0], bus.DDATA_W};

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_full;
  logic pop_req;
  logic pop_do;
  logic push_req;
  logic push_do;
  logic ovf_set;
  logic ovf_clr;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));

  // A POP on an empty FIFO is a plain read of zero; nothing moves.
  assign pop_req = bus_rd & (reg_idx == 2'd3);
  assign pop_do  = pop_req & ~fifo_empty;

  // Change detection runs on the synchronised value against its own
  // one-cycle-delayed copy.
  assign push_req = primed_reg & (s2_reg != prev_reg);

  // A simultaneous pop frees the slot, so a push into a full FIFO is
  // accepted in that case and is not an overflow.
  assign push_do = push_req & (~fifo_full | pop_do);
  assign ovf_set = push_req & fifo_full & ~pop_do;
  assign ovf_clr = bus_wr & (reg_idx == IDX_STATUS) & bus.DDATA_W[10];

  always_comb begin
    count_next = count_reg;
    if (push_do && !pop_do) begin
      count_next = count_reg + CW'(1);
    end else if (pop_do && !push_do) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Set wins over a same-cycle W1C so that no overflow event is lost.
  always_comb begin
    ovf_next = ovf_reg;
    if (ovf_set) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Read-data formatting: zero-extend the DW-bit quantities to the bus width
  // -------------------------------------------------------------------------
  logic [DW-1:0] fifo_head;
  logic [31:0]   dout_word;
  logic [31:0]   din_word;
  logic [31:0]   head_word;
  logic [31:0]   status_word;

  assign fifo_head = mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_ext
      if (gi < DW) begin : g_pin
        assign dout_word[gi] = dout_reg[gi];
        assign din_word[gi]  = s2_reg[gi];
        assign head_word[gi] = fifo_head[gi];
      end else begin : g_pad
        assign dout_word[gi] = 1'b0;
        assign din_word[gi]  = 1'b0;
        assign head_word[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    status_word           = '0;
    status_word[CW-1:0]   = count_reg;
    status_word[8]        = fifo_empty;
    status_word[9]        = fifo_full;
    status_word[10]       = ovf_reg;
  end

  // DDATA_R only changes on a read. Writes and idle cycles leave the last
  // read value on the bus.
  always_comb begin
    ddata_r_next = ddata_r_reg;
    if (bus_rd) begin
      case (reg_idx)
        IDX_DOUT:   ddata_r_next = dout_word;
        IDX_DIN:    ddata_r_next = din_word;
        IDX_STATUS: ddata_r_next = status_word;
        default:    ddata_r_next = pop_do ? head_word : 32'h0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Input synchroniser and change detector
  // -------------------------------------------------------------------------
  // On the first cycle after reset every stage is seeded from the pins. The
  // value present at start-up then becomes the baseline and is not reported
  // as a change. After that the stages shift normally, so a pin change
  // reaches the FIFO two edges after it is first sampled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_reg     <= '0;
      s2_reg     <= '0;
      prev_reg   <= '0;
      primed_reg <= 1'b0;
    end else if (!primed_reg) begin
      s1_reg     <= DIN;
      s2_reg     <= DIN;
      prev_reg   <= DIN;
      primed_reg <= 1'b1;
    end else begin
      s1_reg     <= DIN;
      s2_reg     <= s1_reg;
      prev_reg   <= s2_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Capture FIFO storage (no reset; validity is tracked by count_reg)
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET && push_do) begin
      mem[wr_ptr_reg] <= s2_reg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (push_do) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_do) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      // IRQ is registered together with the count so that both change on
      // the same edge.
      irq_reg   <= (count_next != '0);
    end
  end

  // -------------------------------------------------------------------------
  // Output pin register and read-data register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dout_reg <= DOUT_RST;
    end else if (bus_wr && (reg_idx == IDX_DOUT)) begin
      dout_reg <= bus.DDATA_W[DW-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ddata_r_reg <= '0;
    end else begin
      ddata_r_reg <= ddata_r_next;
    end
  end

  assign DOUT        = dout_reg;
  assign IRQ         = irq_reg;
  assign bus.DDATA_R = ddata_r_reg;

endmodule
